qu_run_ctrl: RTL and testbench

QU_RUN_CTRL -- requirements
Module: qu_run_ctrl

---
 rtl/qu_common.sv | 17 +
 rtl/qu_rr_addr_gen.sv | 34 +++
 rtl/qu_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_qu_run_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// Shared definitions for the qu run-control block.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: core PC width, default core reset length, run-controller state enum.
package qu_common;

  localparam int QU_PC_WIDTH   = 32;
  localparam int QU_RST_CYCLES = 5;

  typedef enum logic [1:0] {
    IDLE,
    CORE_RST,
    RUN,
    DONE
  } run_ctrl_state_t;

endpackage

// File: rtl/qu_rr_addr_gen.sv
// Reservation-station sweep address generator: NUM_PORTS consecutive addresses per cycle.
// Latency: addresses registered, valid the cycle after clr/adv.
// Backpressure: none; advances whenever adv is high.
// Ports: clk/rst (async active-low), clr loads {0..NUM_PORTS-1}, adv steps every
//        address by NUM_PORTS modulo DEPTH, addr is the packed per-port address bus.
module qu_rr_addr_gen #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clr,
  input  logic                                    adv,
  output logic [NUM_PORTS-1:0][$clog2(DEPTH)-1:0] addr
);

  localparam int AW = $clog2(DEPTH);

  // DEPTH is a power of two, so plain AW-bit arithmetic gives the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (clr) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        addr[k] <= AW'(k);
      end
    end else if (adv) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        addr[k] <= addr[k] + AW'(NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/qu_run_ctrl.sv
// Run controller: pulses core reset, runs the core for a set cycle count, injects redirects/stalls.
// Latency: all outputs registered; start -> core_rst next cycle, redirect_req -> core_branch next cycle.
// Backpressure: none; start is ignored while busy, redirect_req is ignored outside RUN.
// Ports: clk, rst (async active-low); start/run_cycles launch a sequence; redirect_req/redirect_pc
//        request a branch; core_* drive the core; rd_addr/rd_valid sweep the reservation station;
//        busy/done/cycle_count report progress.
module qu_run_ctrl
  import qu_common::*;
#(
  parameter int PC_WIDTH     = QU_PC_WIDTH,
  parameter int RST_CYCLES   = QU_RST_CYCLES,
  parameter int CNT_WIDTH    = 16,
  parameter int NUM_RD_PORTS = 2,
  parameter int RES_ST_DEPTH = 16,
  parameter int STALL_PERIOD = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [CNT_WIDTH-1:0]                              run_cycles,
  input  logic                                              redirect_req,
  input  logic [PC_WIDTH-1:0]                               redirect_pc,
  output logic                                              core_rst,
  output logic                                              core_stall,
  output logic                                              core_branch,
  output logic [PC_WIDTH-1:0]                               core_pc_override,
  output logic [NUM_RD_PORTS-1:0][$clog2(RES_ST_DEPTH)-1:0] rd_addr,
  output logic                                              rd_valid,
  output logic                                              busy,
  output logic                                              done,
  output logic [CNT_WIDTH-1:0]                              cycle_count
);

  localparam int RW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW      = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int SP_LAST = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;

  run_ctrl_state_t      state;
  logic [CNT_WIDTH-1:0] run_len;
  logic [RW-1:0]        rst_cnt;
  logic [SW-1:0]        stall_cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 run_last;
  logic                 rst_last;
  logic                 sweep_clr;
  logic                 sweep_adv;

  // Saturating increment; run_len never exceeds the max so the run still ends on time.
  assign cnt_nxt   = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  assign run_last  = (cnt_nxt == run_len);
  assign rst_last  = (rst_cnt == '0);
  assign sweep_clr = (state == CORE_RST) && rst_last && (run_len != '0);
  assign sweep_adv = (state == RUN) && !run_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      core_rst         <= 1'b1;
      core_stall       <= 1'b0;
      core_branch      <= 1'b0;
      core_pc_override <= '0;
      rd_valid         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cycle_count      <= '0;
      run_len          <= '0;
      rst_cnt          <= '0;
      stall_cnt        <= '0;
    end else begin
      core_branch <= 1'b0;
      core_stall  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          core_rst <= 1'b0;
          if (start) begin
            state       <= CORE_RST;
            run_len     <= run_cycles;
            cycle_count <= '0;
            rst_cnt     <= RW'(RST_CYCLES - 1);
            stall_cnt   <= '0;
            core_rst    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        CORE_RST: begin
          // rst_cnt is loaded with RST_CYCLES-1, so core_rst spans exactly RST_CYCLES cycles.
          if (rst_last) begin
            core_rst <= 1'b0;
            if (run_len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              rd_valid <= 1'b1;
            end
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cnt_nxt;
          // stall_cnt tracks cycle_count mod STALL_PERIOD, so the pulse lines up with
          // cycle_count showing a nonzero multiple of the period.
          if (STALL_PERIOD > 0) begin
            if (stall_cnt == SW'(SP_LAST)) begin
              stall_cnt  <= '0;
              core_stall <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
          // Redirect and stall are independent pulses and may coincide; the core is
          // expected to take the redirect first.
          if (redirect_req) begin
            core_branch      <= 1'b1;
            core_pc_override <= redirect_pc;
          end
          if (run_last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            rd_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  qu_rr_addr_gen #(
    .NUM_PORTS (NUM_RD_PORTS),
    .DEPTH     (RES_ST_DEPTH)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (sweep_clr),
    .adv  (sweep_adv),
    .addr (rd_addr)
  );

endmodule

// File: tb/tb_qu_run_ctrl.sv
// Directed bench for qu_run_ctrl: reset values, sequence lengths, sweep addresses,
// stall and redirect injection, start/redirect filtering and mid-run abort.
// Expected values are hand-derived constants and a small modulo address/stall model.
module tb_qu_run_ctrl;

  logic            clk;
  logic            rst;
  logic            start;
  logic [15:0]     run_cycles;
  logic            redirect_req;
  logic [31:0]     redirect_pc;
  logic            core_rst;
  logic            core_stall;
  logic            core_branch;
  logic [31:0]     core_pc_override;
  logic [1:0][3:0] rd_addr;
  logic            rd_valid;
  logic            busy;
  logic            done;
  logic [15:0]     cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  int rst_hi, busy_n, vld_n, stall_n, stall_bad, br_n, br_cyc, req_cyc, addr_bad, run_idx;
  logic [31:0] br_pc;

  qu_run_ctrl #(
    .PC_WIDTH     (32),
    .RST_CYCLES   (5),
    .CNT_WIDTH    (16),
    .NUM_RD_PORTS (2),
    .RES_ST_DEPTH (16),
    .STALL_PERIOD (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .run_cycles       (run_cycles),
    .redirect_req     (redirect_req),
    .redirect_pc      (redirect_pc),
    .core_rst         (core_rst),
    .core_stall       (core_stall),
    .core_branch      (core_branch),
    .core_pc_override (core_pc_override),
    .rd_addr          (rd_addr),
    .rd_valid         (rd_valid),
    .busy             (busy),
    .done             (done),
    .cycle_count      (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one sequence and observe every cycle up to and including the first DONE cycle.
  // redir_at / start_at: RUN cycle (1-based) in which to raise redirect_req / start; 0 = never.
  task automatic run_seq(input logic [15:0] n, input int redir_at, input int start_at);
    logic [3:0] e0;
    rst_hi = 0; busy_n = 0; vld_n = 0; stall_n = 0; stall_bad = 0;
    br_n = 0; br_cyc = -1; req_cyc = -1; addr_bad = 0; run_idx = 0; br_pc = '0;
    start = 1'b1;
    run_cycles = n;
    tick;
    start = 1'b0;
    run_cycles = 16'd3;
    chk("start_core_rst", core_rst, 1);
    chk("start_done_clr", done, 0);
    for (int c = 0; c < 200; c++) begin
      redirect_req = 1'b0;
      start = 1'b0;
      if (core_rst) rst_hi++;
      if (busy) busy_n++;
      if (core_stall) stall_n++;
      if (core_stall !== (cycle_count != 0 && cycle_count % 4 == 0)) stall_bad++;
      if (core_branch) begin
        br_n++;
        br_cyc = c;
        br_pc = core_pc_override;
      end
      if (rd_valid) begin
        e0 = 4'(2 * run_idx);
        if (rd_addr[0] !== e0 || rd_addr[1] !== e0 + 4'd1) addr_bad++;
        vld_n++;
        run_idx++;
        if (run_idx == redir_at) begin
          redirect_req = 1'b1;
          redirect_pc = 32'h100;
          req_cyc = c;
        end
        if (run_idx == start_at) start = 1'b1;
      end
      if (done) break;
      tick;
    end
    redirect_req = 1'b0;
    start = 1'b0;
    chk("seq_reached_done", done, 1);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    start = 1'b0;
    run_cycles = '0;
    redirect_req = 1'b0;
    redirect_pc = '0;

    #12;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_branch", core_branch, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_pc_override", core_pc_override, 0);

    tick;
    rst = 1'b1;
    tick;
    chk("idle_core_rst_drop", core_rst, 0);

    // Redirect while idle must not pulse.
    redirect_req = 1'b1;
    redirect_pc = 32'h55;
    tick;
    chk("idle_redirect_0", core_branch, 0);
    tick;
    chk("idle_redirect_1", core_branch, 0);
    redirect_req = 1'b0;

    // run 10, with a stray start in RUN cycle 2
    run_seq(16'd10, 0, 2);
    chk("r10_core_rst_cycles", rst_hi, 5);
    chk("r10_busy_cycles", busy_n, 15);
    chk("r10_valid_cycles", vld_n, 10);
    chk("r10_cycle_count", cycle_count, 10);
    chk("r10_addr_errors", addr_bad, 0);
    chk("r10_stall_pulses", stall_n, 2);
    chk("r10_stall_errors", stall_bad, 0);
    chk("r10_branch_pulses", br_n, 0);
    tick;
    tick;
    chk("r10_done_held", done, 1);
    chk("r10_busy_after", busy, 0);

    // run 0: reset pulse only, straight to DONE
    run_seq(16'd0, 0, 0);
    chk("r0_core_rst_cycles", rst_hi, 5);
    chk("r0_busy_cycles", busy_n, 5);
    chk("r0_valid_cycles", vld_n, 0);
    chk("r0_cycle_count", cycle_count, 0);

    // run 12 with a redirect in RUN cycle 3
    run_seq(16'd12, 3, 0);
    chk("r12_cycle_count", cycle_count, 12);
    chk("r12_valid_cycles", vld_n, 12);
    chk("r12_addr_errors", addr_bad, 0);
    chk("r12_stall_pulses", stall_n, 3);
    chk("r12_stall_errors", stall_bad, 0);
    chk("r12_branch_pulses", br_n, 1);
    chk("r12_branch_delay", br_cyc - req_cyc, 1);
    chk("r12_branch_pc", br_pc, 32'h100);

    // Redirect in DONE: no pulse, override keeps its last value.
    redirect_pc = 32'h200;
    redirect_req = 1'b1;
    tick;
    chk("done_redirect", core_branch, 0);
    chk("done_pc_hold", core_pc_override, 32'h100);
    redirect_req = 1'b0;

    // Abort in RUN cycle 5.
    start = 1'b1;
    run_cycles = 16'd10;
    tick;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 50; c++) begin
      if (rd_valid) k++;
      if (k == 5) break;
      tick;
    end
    chk("abort_reached_run5", k, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_core_rst", core_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_cycle_count", cycle_count, 0);
    chk("abort_rd_addr", rd_addr, 0);
    tick;
    rst = 1'b1;
    tick;
    tick;
    chk("abort_no_done", done, 0);
    chk("abort_no_busy", busy, 0);
    chk("abort_core_rst_drop", core_rst, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
